// File: rtl/rsc_encoder_if.sv
// Block-level stream interface of the RSC encoder: block length request,
// information bits in, interleaved sys/parity soft words out.
interface rsc_encoder_if;
    logic [15:0]        blklen;
    logic               valid_blklen;
    logic               data_in;
    logic               valid_data;
    logic               ready;
    logic signed [15:0] out;
    logic               valid_out;
    logic               last_out;

    modport master (
        output blklen, valid_blklen, data_in, valid_data,
        input  ready, out, valid_out, last_out
    );

    modport slave (
        input  blklen, valid_blklen, data_in, valid_data,
        output ready, out, valid_out, last_out
    );
endinterface

// File: rtl/rsc_encoder.sv
// Rate-1/2 RSC encoder (fb 1+D^2+D^3, ff 1+D+D^3) emitting an interleaved
// sys/parity soft-value stream followed by a 3-bit trellis termination.
//
// state | meaning
// IDLE  | waiting for a non-zero block length
// DATA  | accepting K information bits, each emitted as a sys/parity pair
// TAIL  | emitting 3 termination pairs that drive the trellis back to zero
module rsc_encoder #(
    parameter logic signed [15:0] AMP = 16'sd1024
) (
    input  logic         clk,
    input  logic         rst,
    rsc_encoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t      state_q, state_d;
    logic        ph;
    logic [15:0] count;
    logic [15:0] k_len;
    logic [2:0]  trellis;     // [0] = s0 (most recent), [2] = s2
    logic        par_q;
    logic [1:0]  tail_cnt;

    logic start, accept, emit_par, emit_tail, tail_done, rdy;
    logic u_bit, f_bit, p_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        accept    = 1'b0;
        emit_par  = 1'b0;
        emit_tail = 1'b0;
        tail_done = 1'b0;
        rdy       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_blklen && (bus.blklen != 16'd0)) begin
                    start   = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ph) begin
                    emit_par = 1'b1;
                    if (count == k_len) state_d = TAIL;
                end else if (count < k_len) begin
                    rdy    = 1'b1;
                    accept = bus.valid_data;
                end
            end
            TAIL: begin
                if (ph) begin
                    emit_par = 1'b1;
                    if (tail_cnt == 2'd3) begin
                        tail_done = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    emit_tail = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready = rdy;

    // Termination input cancels the feedback, forcing f = 0.
    assign u_bit = emit_tail ? (trellis[1] ^ trellis[2]) : bus.data_in;
    assign f_bit = u_bit ^ trellis[1] ^ trellis[2];
    assign p_bit = f_bit ^ trellis[0] ^ trellis[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph            <= 1'b0;
            count         <= 16'd0;
            k_len         <= 16'd0;
            trellis       <= 3'b000;
            par_q         <= 1'b0;
            tail_cnt      <= 2'd0;
            bus.out       <= 16'sd0;
            bus.valid_out <= 1'b0;
            bus.last_out  <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            bus.last_out  <= 1'b0;
            if (start) begin
                k_len    <= bus.blklen;
                count    <= 16'd0;
                trellis  <= 3'b000;
                ph       <= 1'b0;
                tail_cnt <= 2'd0;
            end
            if (accept || emit_tail) begin
                bus.out       <= u_bit ? -AMP : AMP;
                bus.valid_out <= 1'b1;
                ph            <= 1'b1;
                par_q         <= p_bit;
                trellis       <= {trellis[1:0], f_bit};
            end
            if (accept)    count    <= count + 16'd1;
            if (emit_tail) tail_cnt <= tail_cnt + 2'd1;
            if (emit_par) begin
                bus.out       <= par_q ? -AMP : AMP;
                bus.valid_out <= 1'b1;
                ph            <= 1'b0;
                bus.last_out  <= tail_done;
            end
        end
    end

endmodule

// File: tb/tb_rsc_encoder.sv
// Randomized self-checking bench for rsc_encoder against a queue-based
// reference encoder computed directly from the code polynomials.
module tb_rsc_encoder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rsc_encoder_if bus ();

    rsc_encoder #(.AMP(16'sd1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int got[$];
    int n_last   = 0;
    int last_idx = 0;
    int viol     = 0;
    int gaps     = 0;
    int cur_k    = 0;
    int last_exp = 0;

    task automatic check_eq(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int amp_of(input int b);
        return (b != 0) ? -1024 : 1024;
    endfunction

    // Reference: walk the bit list with integer state, then three
    // termination bits chosen so the feedback sum is zero.
    task automatic build_model(input bit bits[$], output int exp_q[$]);
        int s0 = 0, s1 = 0, s2 = 0;
        int u, f, p;
        exp_q.delete();
        for (int i = 0; i < bits.size() + 3; i++) begin
            u = (i < bits.size()) ? int'(bits[i]) : (s1 ^ s2);
            f = u ^ s1 ^ s2;
            p = f ^ s0 ^ s2;
            exp_q.push_back(amp_of(u));
            exp_q.push_back(amp_of(p));
            s2 = s1;
            s1 = s0;
            s0 = f;
        end
    endtask

    always @(negedge clk) begin
        if (bus.last_out) begin
            n_last++;
            if (!bus.valid_out) viol++;
        end
        if (bus.valid_out) begin
            got.push_back(int'(bus.out));
            if (bus.last_out) last_idx = got.size();
            if ((got.size() % 2) == 1 && bus.ready) viol++;
        end else if (rst && cur_k > 0 &&
                     (((got.size() % 2) == 1) ||
                      (got.size() >= 2 * cur_k && got.size() < 2 * cur_k + 6))) begin
            gaps++;
        end
    end

    task automatic run_block(input int k, input bit rnd_data, input bit first_one,
                             input bit gapped, input bit blk_pulse, input int abort_after);
        bit bits[$];
        int exp_q[$];
        int idx  = 0;
        int cyc  = 0;
        bit done = 1'b0;
        int f0;
        for (int i = 0; i < k; i++)
            bits.push_back(rnd_data ? bit'($urandom % 2) : (first_one && i == 0));
        build_model(bits, exp_q);
        got.delete();
        n_last = 0; last_idx = 0; viol = 0; gaps = 0; cur_k = k;
        bus.blklen       = 16'(k);
        bus.valid_blklen = 1'b1;
        @(posedge clk); #1;
        bus.valid_blklen = 1'b0;
        while (!done && cyc < 8 * k + 200 && !(abort_after >= 0 && idx >= abort_after)) begin
            bus.valid_data = 1'b0;
            if (!gapped || ($urandom % 2) == 1) begin
                bus.valid_data = 1'b1;
                if (bus.ready) begin
                    bus.data_in = bits[idx];
                    idx++;
                end else begin
                    bus.data_in = 1'($urandom % 2);
                end
            end
            if (blk_pulse && cyc == 20) begin
                bus.blklen       = 16'd100;
                bus.valid_blklen = 1'b1;
            end else begin
                bus.valid_blklen = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (bus.last_out) done = 1'b1;
        end
        bus.valid_data   = 1'b0;
        bus.valid_blklen = 1'b0;
        if (abort_after >= 0) return;
        @(negedge clk); #1;
        check_eq("blk_done", int'(done), 1);
        check_eq("n_words", got.size(), 2 * k + 6);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            f0 = n_fail;
            check_eq($sformatf("word[%0d]", i), got[i], exp_q[i]);
            if (n_fail != f0) break;
        end
        check_eq("n_last", n_last, 1);
        check_eq("last_pos", last_idx, 2 * k + 6);
        check_eq("rdy_or_pair", viol, 0);
        check_eq("gap", gaps, 0);
        check_eq("trellis_end", int'(dut.trellis), 0);
        last_exp = exp_q[exp_q.size() - 1];
        cur_k = 0;
    endtask

    initial begin
        int k;
        bus.blklen       = 16'd0;
        bus.valid_blklen = 1'b0;
        bus.data_in      = 1'b0;
        bus.valid_data   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out", int'(bus.out), 0);
        check_eq("rst_valid", int'(bus.valid_out), 0);
        check_eq("rst_ready", int'(bus.ready), 0);
        check_eq("rst_last", int'(bus.last_out), 0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_ready", int'(bus.ready), 0);

        bus.blklen = 16'd0; bus.valid_blklen = 1'b1;
        @(posedge clk); #1;
        bus.valid_blklen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("k0_ready", int'(bus.ready), 0);
        check_eq("k0_valid", int'(bus.valid_out), 0);

        run_block(40, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_block(40, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        check_eq("first_w1", got[0], -1024);
        check_eq("first_w2", got[1], -1024);
        check_eq("first_w3", got[2], 1024);
        check_eq("first_w4", got[3], -1024);

        repeat (4) @(posedge clk);
        #1;
        check_eq("hold_valid", int'(bus.valid_out), 0);
        check_eq("hold_out", int'(bus.out), last_exp);

        run_block(40, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        run_block(40, 1'b1, 1'b0, 1'b0, 1'b1, -1);

        run_block(40, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        rst = 1'b0;
        #1;
        check_eq("abort_out", int'(bus.out), 0);
        check_eq("abort_valid", int'(bus.valid_out), 0);
        check_eq("abort_ready", int'(bus.ready), 0);
        repeat (3) @(posedge clk);
        check_eq("abort_nolast", n_last, 0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst_valid", int'(bus.valid_out), 0);
        check_eq("post_rst_ready", int'(bus.ready), 0);
        run_block(40, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        run_block($urandom_range(1, 200), 1'b1, 1'b0, 1'b1, 1'b0, -1);
        for (int b = 0; b < 3; b++) begin
            k = $urandom_range(1, 6144);
            run_block(k, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        end
        run_block(1, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsc_encoder.md
RSC_ENCODER -- requirements
Module: rsc_encoder

Interface
REQ-001 SHALL have parameter AMP, default 16'sd1024: magnitude of the emitted soft value.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port blklen, input, 16 bits: information block length K, in bits.
REQ-005 SHALL have port valid_blklen, input, 1 bit: qualifies blklen and starts a block.
REQ-006 SHALL have port data_in, input, 1 bit: information bit.
REQ-007 SHALL have port valid_data, input, 1 bit: qualifies data_in.
REQ-008 SHALL have port ready, output, 1 bit: the block can accept data_in this cycle.
REQ-009 SHALL have port out, output, 16 bits: signed soft word, delivered as a sys/parity interleaved stream.
REQ-010 SHALL have port valid_out, output, 1 bit: qualifies out.
REQ-011 SHALL have port last_out, output, 1 bit: marks the final word of a block.

Function
REQ-012 SHALL implement the rate-1/2 RSC code with feedback 1+D^2+D^3 and feedforward 1+D+D^3, using 3-bit state s0,s1,s2 (s0 is the most recent).
REQ-013 For each bit, SHALL compute f = u^s1^s2 and parity p = f^s0^s2, then update the state to {s0<-f, s1<-s0, s2<-s1}.
REQ-014 SHALL map bit 0 to +AMP and bit 1 to -AMP, two's complement.
REQ-015 SHALL use FSM states IDLE, DATA and TAIL; the internal sys/parity phase flag is ph.
REQ-016 IDLE -> DATA SHALL occur on valid_blklen=1 with blklen!=0; this latches K and clears the bit counter and the trellis state.
REQ-017 valid_blklen with blklen=0 SHALL be ignored.
REQ-018 valid_blklen in DATA or TAIL SHALL be ignored.
REQ-019 ready SHALL equal (state==DATA && ph==0 && count<K).
REQ-020 A bit SHALL be accepted when valid_data && ready.
REQ-021 valid_data while ready=0 SHALL be ignored; data is not buffered.
REQ-022 On acceptance, the next cycle SHALL output out=map(u) and valid_out=1 (one-cycle latency); ph is set to 1 and p is registered.
REQ-023 The cycle after the sys word, the block SHALL output out=map(p) and valid_out=1, and clear ph.
REQ-024 Sys and parity words SHALL always be adjacent.
REQ-025 Throughput SHALL be at most 1 bit per 2 cycles.
REQ-026 With no acceptance and ph==0, valid_out SHALL be 0 and out SHALL hold its last value.
REQ-027 After the parity word of bit K, the block SHALL enter TAIL.
REQ-028 TAIL SHALL emit 3 termination bits, each with u = s1^s2 (so f=0), as sys/parity pairs.
REQ-029 TAIL SHALL emit 6 consecutive valid_out cycles with no gaps and without regard to valid_data.
REQ-030 last_out SHALL be 1 only with the 6th tail word; after it the FSM SHALL return to IDLE.
REQ-031 The trellis state SHALL be 0 at the end of TAIL.
REQ-032 Each block SHALL emit exactly 2K+6 words.
REQ-033 The next block's valid_blklen SHALL be accepted in the cycle after last_out.
REQ-034 The bit counter SHALL be 16 bits; K up to 65535 is supported, with no wrap within a block.

Reset
REQ-035 While rst=0, the block SHALL force: state=IDLE, ph=0, count=0, trellis=0, K=0, ready=0, valid_out=0, last_out=0, out=0.
REQ-036 rst assertion mid-block SHALL abort the block immediately, with no tail and no last_out.
REQ-037 After rst release, the block SHALL wait in IDLE for valid_blklen.

Verification
REQ-038 K=40, all-zero data on every ready cycle -> 86 valid words, all +1024; last_out on the 86th word; no other last_out.
REQ-039 K=40, first bit 1 then zeros -> words 1..4 = -1024, -1024, +1024, -1024; total 86 words; golden C/Matlab model matches every word including the tail.
REQ-040 K=40 with valid_data toggled randomly -> ready never 1 on a parity cycle; sys/parity always adjacent; output identical to the gap-free run.
REQ-041 valid_blklen pulsed during DATA with blklen=100 -> ignored; block still ends after 2*40+6 words.
REQ-042 rst asserted after 10 accepted bits, then K=40 restarted -> outputs 0 during reset; no last_out for the aborted block; new block output matches a fresh run.
REQ-043 Random K in 1..6144 with random data -> word count 2K+6 and final trellis state 0 for every block.
